id_stage: RTL

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 120 ++++++++++++
 1 files changed

// File: rtl/id_stage.sv
// Instruction decode stage: decodes a 16-bit instruction, reads operands with writeback
// bypass, tracks pending destinations in a scoreboard and stalls on read-after-write hazards.
module id_stage #(
    parameter int unsigned STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [15:0]        in_instr,
    output logic               in_ready,
    output logic [3:0]         ra,
    output logic [3:0]         rb,
    input  logic [7:0]         read_a,
    input  logic [7:0]         read_b,
    input  logic               wb_we,
    input  logic [3:0]         wb_wa,
    input  logic [7:0]         wb_wd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_op,
    output logic [3:0]         out_rd,
    output logic [7:0]         out_a,
    output logic [7:0]         out_b,
    output logic               out_we,
    output logic [STALL_W-1:0] stall_cnt
);

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDI = 4'hF
    } op_e;

    logic [3:0]  op, rd, rs1, rs2;
    logic [7:0]  imm8;
    logic        uses_src, we_dec, hazard, accept;
    logic        blk1, blk2;
    logic [7:0]  opnd_a, opnd_b;
    logic [15:0] pending, pending_nxt;

    assign op   = in_instr[15:12];
    assign rd   = in_instr[11:8];
    assign rs1  = in_instr[7:4];
    assign rs2  = in_instr[3:0];
    assign imm8 = in_instr[7:0];
    assign ra   = rs1;
    assign rb   = rs2;

    assign uses_src = (op != OP_NOP) && (op != OP_LDI);
    assign we_dec   = (op != OP_NOP) && (rd != 4'd0);

    // A writeback landing this cycle unblocks its register because the operand is bypassed.
    assign blk1 = (rs1 != 4'd0) && pending[rs1] && !(wb_we && (wb_wa == rs1));
    assign blk2 = (rs2 != 4'd0) && pending[rs2] && !(wb_we && (wb_wa == rs2));

    assign hazard   = in_valid && uses_src && (blk1 || blk2);
    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    always_comb begin
        opnd_a = '0;
        opnd_b = '0;
        if (op == OP_LDI) begin
            opnd_a = imm8;
        end else if (uses_src) begin
            if (rs1 == 4'd0)                    opnd_a = '0;
            else if (wb_we && (wb_wa == rs1))   opnd_a = wb_wd;
            else                                opnd_a = read_a;
            if (rs2 == 4'd0)                    opnd_b = '0;
            else if (wb_we && (wb_wa == rs2))   opnd_b = wb_wd;
            else                                opnd_b = read_b;
        end
    end

    // Clear is applied before set so a same-cycle set of the same register wins.
    always_comb begin
        pending_nxt = pending;
        if (wb_we && (wb_wa != 4'd0))
            pending_nxt[wb_wa] = 1'b0;
        if (accept && we_dec)
            pending_nxt[rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_op    <= '0;
            out_rd    <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_we    <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_op    <= op;
            out_rd    <= rd;
            out_a     <= opnd_a;
            out_b     <= opnd_b;
            out_we    <= we_dec;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (hazard && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

endmodule
